// File: rtl/audio_sample_pacer.sv
// Audio sample pacer: fractional-rate tick generator that pulls stereo samples
// from a valid/ready source into a small FIFO drained by the data island packetizer.
module audio_sample_pacer #(
    parameter int DEPTH     = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                     pixelClock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [ACC_WIDTH-1:0]     rateIncrement,
    input  logic [ACC_WIDTH-1:0]     rateModulus,
    input  logic [31:0]              sourceData,
    input  logic                     sourceValid,
    output logic                     sourceReady,
    output logic                     sampleTick,
    input  logic                     sampleFifoReadEnable,
    output logic                     sampleFifoEmpty,
    output logic [31:0]              sampleFifoReadData,
    output logic [$clog2(DEPTH):0]   fifoLevel,
    output logic [15:0]              underrunCount,
    output logic [15:0]              overflowCount
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH:0]   wrapped;
    logic                 config_error;
    logic                 tick;

    logic [31:0]          mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [31:0]          read_data;
    logic [31:0]          last_sample;
    logic [31:0]          push_data;
    logic [15:0]          underrun_count;
    logic [15:0]          overflow_count;

    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 write;
    logic                 drop;
    logic                 underrun;

    // One extra bit so the increment can never wrap before the modulus compare.
    assign sum          = {1'b0, acc} + {1'b0, rateIncrement};
    assign wrapped      = sum - {1'b0, rateModulus};
    assign config_error = (rateModulus == '0) || (rateIncrement >= rateModulus);

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (config_error) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            if (sum >= {1'b0, rateModulus}) begin
                acc  <= wrapped[ACC_WIDTH-1:0];
                tick <= 1'b1;
            end else begin
                acc  <= sum[ACC_WIDTH-1:0];
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    assign push      = tick;
    assign full      = (level == LVL_W'(DEPTH));
    assign pop       = sampleFifoReadEnable && (level != '0);
    // A pop in the same cycle frees the slot, so a full FIFO only drops when nothing leaves.
    assign write     = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign underrun  = push && !sourceValid;
    assign push_data = sourceValid ? sourceData : last_sample;

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            read_data      <= '0;
            last_sample    <= '0;
            underrun_count <= '0;
            overflow_count <= '0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                read_data <= mem[rd_ptr];
            end
            if (push && sourceValid) begin
                last_sample <= sourceData;
            end
            if (write && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !write) begin
                level <= level - LVL_W'(1);
            end
            if (underrun && (underrun_count != 16'hFFFF)) begin
                underrun_count <= underrun_count + 16'd1;
            end
            if (drop && (overflow_count != 16'hFFFF)) begin
                overflow_count <= overflow_count + 16'd1;
            end
        end
    end

    // Storage carries no reset; the pointers and level define which entries are live.
    always_ff @(posedge pixelClock) begin
        if (write) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign sourceReady        = tick;
    assign sampleTick         = tick;
    assign sampleFifoEmpty    = (level == '0);
    assign sampleFifoReadData = read_data;
    assign fifoLevel          = level;
    assign underrunCount      = underrun_count;
    assign overflowCount      = overflow_count;

endmodule
